// File: rtl/conv_result_writer.sv
// ============================================================================
// Module   : conv_result_writer
// Purpose  : Collects one quantized convolution result per save_rstl rising
//            edge and writes it to the feature-map RAM in row-major order.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_result_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_ROWS   = 26,
  parameter int OUT_COLS   = 26,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  save_rstl,
  input  logic [DATA_WIDTH-1:0] out_quant,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] row,
  output logic [ADDR_WIDTH-1:0] col,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_LAST_ROW = ADDR_WIDTH'(OUT_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] C_LAST_COL = ADDR_WIDTH'(OUT_COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] C_ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] C_ZERO     = '0;

  state_t                r_state, w_state;
  logic                  r_save_d;
  logic                  r_wr_en, w_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data;
  logic [ADDR_WIDTH-1:0] r_row, w_row;
  logic [ADDR_WIDTH-1:0] r_col, w_col;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  w_edge;

  assign w_edge = save_rstl & ~r_save_d;

  always_comb begin
    w_state   = r_state;
    w_wr_en   = 1'b0;
    w_wr_addr = r_wr_addr;
    w_wr_data = r_wr_data;
    w_row     = r_row;
    w_col     = r_col;
    w_busy    = r_busy;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_row     = C_ZERO;
          w_col     = C_ZERO;
          w_wr_addr = C_ZERO;
          w_busy    = 1'b1;
          w_state   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_edge) begin
          w_wr_data = out_quant;
          w_wr_en   = 1'b1;
          w_state   = S_WRITE;
        end
      end
      S_WRITE: begin
        // The last pixel keeps its position so row/col/addr still name it after done.
        if (r_row == C_LAST_ROW && r_col == C_LAST_COL) begin
          w_state = S_DONE;
        end else begin
          if (r_col == C_LAST_COL) begin
            w_col = C_ZERO;
            w_row = r_row + C_ONE;
          end else begin
            w_col = r_col + C_ONE;
          end
          w_wr_addr = r_wr_addr + C_ONE;
          w_state   = S_WAIT;
        end
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_save_d  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (en) begin
      r_state   <= w_state;
      r_save_d  <= save_rstl;
      r_wr_en   <= w_wr_en;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
      r_row     <= w_row;
      r_col     <= w_col;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end else begin
      // Frozen: everything holds except the write strobe, which must not repeat.
      r_wr_en <= 1'b0;
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign row     = r_row;
  assign col     = r_col;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_conv_result_writer.sv
// ============================================================================
// Module   : tb_conv_result_writer
// Purpose  : Self-checking bench for conv_result_writer on a 2x3 frame.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv_result_writer;

  localparam int DW   = 8;
  localparam int ROWS = 2;
  localparam int COLS = 3;
  localparam int AW   = 4;
  localparam int NPIX = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b1;
  logic          start = 1'b0;
  logic          save_rstl = 1'b0;
  logic [DW-1:0] out_quant = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] row;
  logic [AW-1:0] col;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  conv_result_writer #(
    .DATA_WIDTH(DW), .OUT_ROWS(ROWS), .OUT_COLS(COLS), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .save_rstl(save_rstl),
    .out_quant(out_quant), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .row(row), .col(col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Observed RAM writes and done pulses, sampled mid-cycle.
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  logic [AW-1:0] log_row[$];
  logic [AW-1:0] log_col[$];
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_row.push_back(row);
      log_col.push_back(col);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_row.delete();
    log_col.delete();
    done_cnt = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse(input logic [DW-1:0] d, input int hi, input int lo);
    out_quant = d;
    save_rstl = 1'b1;
    repeat (hi) tick();
    save_rstl = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    n_tests++;
    if ({wr_en, wr_addr, wr_data, row, col, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got en=%b addr=%0d data=%0d row=%0d col=%0d busy=%b done=%b, want all 0",
               wr_en, wr_addr, wr_data, row, col, busy, done);
    end
    rst = 1'b1;
    tick();
  endtask

  // Runs one frame with the given pixel values and random gaps, checking every
  // write against row-major order.
  task automatic run_frame(input string name, input logic [DW-1:0] px[NPIX]);
    clear_log();
    do_start();
    for (int p = 0; p < NPIX; p++)
      pulse(px[p], $urandom_range(1, 3), $urandom_range(1, 3));
    repeat (6) tick();
    n_tests++;
    if (log_addr.size() != NPIX) begin
      n_fail++;
      $display("FAIL %s_count: got %0d writes, want %0d", name, log_addr.size(), NPIX);
    end
    for (int p = 0; p < NPIX && p < log_addr.size(); p++) begin
      n_tests++;
      if (log_addr[p] !== AW'(p) || log_data[p] !== px[p] ||
          log_row[p] !== AW'(p / COLS) || log_col[p] !== AW'(p % COLS)) begin
        n_fail++;
        $display("FAIL %s_pix%0d: got addr=%0d data=%0d row=%0d col=%0d, want addr=%0d data=%0d row=%0d col=%0d",
                 name, p, log_addr[p], log_data[p], log_row[p], log_col[p],
                 p, px[p], p / COLS, p % COLS);
      end
    end
    n_tests++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: got done pulses=%0d busy=%b, want 1 and 0", name, done_cnt, busy);
    end
  endtask

  task automatic test_full_frame();
    logic [DW-1:0] px[NPIX];
    for (int p = 0; p < NPIX; p++) px[p] = DW'(10 + p);
    run_frame("full_frame", px);
  endtask

  task automatic test_random_frames();
    logic [DW-1:0] px[NPIX];
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < NPIX; p++) px[p] = DW'($urandom_range(0, 255));
      run_frame($sformatf("rand_frame%0d", f), px);
    end
  endtask

  task automatic test_long_strobe();
    clear_log();
    do_start();
    pulse(8'h7F, 4, 3);
    n_tests++;
    if (log_addr.size() != 1) begin
      n_fail++;
      $display("FAIL long_strobe_count: got %0d wr_en cycles, want 1", log_addr.size());
    end else begin
      n_tests++;
      if (log_data[0] !== 8'h7F || log_addr[0] !== '0) begin
        n_fail++;
        $display("FAIL long_strobe_data: got addr=%0d data=%0h, want 0 and 7f", log_addr[0], log_data[0]);
      end
    end
    do_reset();
  endtask

  task automatic test_ignored_inputs();
    clear_log();
    pulse(8'hA5, 1, 3);
    n_tests++;
    if (log_addr.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_edge: got %0d writes busy=%b, want 0 writes busy=0", log_addr.size(), busy);
    end
    do_start();
    pulse(8'h11, 1, 2);
    do_start();
    tick();
    n_tests++;
    if (row !== AW'(0) || col !== AW'(1) || wr_addr !== AW'(1) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_wait: got row=%0d col=%0d addr=%0d busy=%b, want 0 1 1 1", row, col, wr_addr, busy);
    end
    pulse(8'h22, 1, 2);
    n_tests++;
    if (log_addr.size() != 2 || log_addr[1] !== AW'(1) || log_data[1] !== 8'h22) begin
      n_fail++;
      $display("FAIL start_in_wait_next: got %0d writes, want 2 with second at addr 1 data 22", log_addr.size());
    end
    do_reset();
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    do_start();
    pulse(8'h31, 1, 2);
    pulse(8'h32, 1, 2);
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if ({wr_en, wr_addr, wr_data, row, col, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got en=%b addr=%0d data=%0d row=%0d col=%0d busy=%b done=%b, want all 0",
               wr_en, wr_addr, wr_data, row, col, busy, done);
    end
    tick();
    rst = 1'b1;
    tick();
    clear_log();
    pulse(8'h33, 1, 3);
    n_tests++;
    if (log_addr.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_edge: got %0d writes busy=%b, want 0 writes busy=0", log_addr.size(), busy);
    end
    do_start();
    pulse(8'h34, 1, 2);
    n_tests++;
    if (log_addr.size() != 1 || log_addr[0] !== '0 || log_data[0] !== 8'h34) begin
      n_fail++;
      $display("FAIL restart_after_reset: got %0d writes, want 1 at addr 0 data 34", log_addr.size());
    end
    do_reset();
  endtask

  task automatic test_enable_freeze();
    int bad;
    clear_log();
    do_start();
    out_quant = 8'h5C;
    save_rstl = 1'b1;
    en        = 1'b0;
    bad       = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wr_en !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL freeze_wr_en: got wr_en high in %0d frozen cycles, want 0", bad);
    end
    en = 1'b1;
    tick();
    save_rstl = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (log_addr.size() != 1 || log_data[0] !== 8'h5C || log_addr[0] !== '0) begin
      n_fail++;
      $display("FAIL freeze_write: got %0d writes, want 1 at addr 0 data 5c", log_addr.size());
    end
    n_tests++;
    if (col !== AW'(1) || wr_addr !== AW'(1)) begin
      n_fail++;
      $display("FAIL freeze_advance: got col=%0d addr=%0d, want 1 and 1", col, wr_addr);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_frames();
    test_long_strobe();
    test_ignored_inputs();
    test_reset_mid_frame();
    test_enable_freeze();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/conv_result_writer.md
CONV_RESULT_WRITER -- requirements
Module: conv_result_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the width of the quantized convolution result.
REQ-002 SHALL have parameter OUT_ROWS, default 26, meaning the number of feature-map rows per frame.
REQ-003 SHALL have parameter OUT_COLS, default 26, meaning the number of feature-map columns per frame.
REQ-004 SHALL have parameter ADDR_WIDTH, default 10, meaning the feature-map address width; it must satisfy 2^ADDR_WIDTH >= OUT_ROWS*OUT_COLS.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port en, input, 1 bit: global enable; when low, all state is held.
REQ-008 SHALL have port start, input, 1 bit: a one-cycle request to begin collecting a frame.
REQ-009 SHALL have port save_rstl, input, 1 bit: the result-valid strobe from the convolution unit; its rising edge marks a new result.
REQ-010 SHALL have port out_quant, input, DATA_WIDTH bits: the quantized and ReLU'd result from the convolution unit.
REQ-011 SHALL have port wr_en, output, 1 bit: the feature-map RAM write strobe.
REQ-012 SHALL have port wr_addr, output, ADDR_WIDTH bits: the RAM write address, equal to row*OUT_COLS+col.
REQ-013 SHALL have port wr_data, output, DATA_WIDTH bits: the RAM write data.
REQ-014 SHALL have ports row and col, output, ADDR_WIDTH bits each: the current output-pixel position.
REQ-015 SHALL have port busy, output, 1 bit: high while a frame is being collected.
REQ-016 SHALL have port done, output, 1 bit: a one-cycle pulse after the last pixel is written.

Function
REQ-017 SHALL implement an FSM with states IDLE, WAIT, WRITE and DONE; all outputs SHALL be registered.
REQ-018 SHALL register save_rstl into save_d every enabled cycle; an edge is the condition save_rstl=1 and save_d=0.
REQ-019 IDLE: on start=1, SHALL clear row, col and wr_addr to 0, set busy=1 and go to WAIT; edges seen in IDLE SHALL be ignored.
REQ-020 WAIT: on an edge, SHALL capture out_quant into wr_data, set wr_en=1 and go to WRITE.
REQ-021 WAIT, latency: wr_en SHALL be high exactly one cycle, in the cycle after the posedge where the edge was sampled.
REQ-022 WRITE: SHALL drop wr_en to 0; if col=OUT_COLS-1, col SHALL wrap to 0 and row SHALL increment, otherwise col SHALL increment; wr_addr SHALL increment by 1.
REQ-023 WRITE, last pixel: if row=OUT_ROWS-1 and col=OUT_COLS-1, SHALL go to DONE with row, col and wr_addr unchanged; otherwise SHALL return to WAIT.
REQ-024 DONE: SHALL pulse done=1 for one cycle, clear busy and go to IDLE.
REQ-025 start asserted outside IDLE SHALL be ignored.
REQ-026 A save_rstl held high for multiple cycles SHALL produce exactly one write.
REQ-027 An edge arriving in WRITE or DONE SHALL be dropped; the convolution unit guarantees at least 2 cycles between edges.
REQ-028 When en=0, FSM state, counters, save_d and all outputs SHALL hold; wr_en SHALL be forced to 0; edges spanning the en=0 window SHALL be evaluated against the held save_d.
REQ-029 wr_data SHALL be passed through unmodified, with no sign or width conversion.

Reset
REQ-030 With rst=0, SHALL immediately (asynchronously) set state=IDLE and wr_en, wr_addr, wr_data, row, col, busy, done and save_d all to 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no further writes; a new start SHALL be required.

Verification (OUT_ROWS=2, OUT_COLS=3)
REQ-032 Reset mid-frame: rst low after 2 writes -> all outputs 0 asynchronously; next edge causes no write until start.
REQ-033 Full frame: start, then 6 save_rstl pulses with out_quant=10..15 -> writes (addr,data) = (0,10)..(5,15); row/col sequence 0/0,0/1,0/2,1/0,1/1,1/2; done pulses once; busy low after.
REQ-034 Long strobe: save_rstl held high 4 cycles with out_quant=0x7F -> exactly one write of 0x7F, wr_en high 1 cycle.
REQ-035 Ignored inputs: edge while IDLE -> no write; start during WAIT -> counters unchanged.
REQ-036 Enable freeze: en=0 for 5 cycles between edge and WRITE -> wr_en stays 0 during the freeze, then the write completes once with the captured data.
